// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: gathers one tile of K_DEPTH k-vectors over a
// valid/ready handshake, then replays it with a diagonal skew (lane i
// delayed by i beats, zero outside its window) into the MAC array.

// One lane of the skew: shows slot t-LANE of this lane's column while it
// falls inside the K_DEPTH window, zero otherwise.
module systolic_skew_lane #(
  parameter int K_DEPTH    = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TW         = 4,
  parameter int LANE       = 0
) (
  input  logic [TW-1:0]                      t,
  input  logic [K_DEPTH-1:0][DATA_WIDTH-1:0] col_a,
  input  logic [K_DEPTH-1:0][DATA_WIDTH-1:0] col_b,
  output logic [DATA_WIDTH-1:0]              a,
  output logic [DATA_WIDTH-1:0]              b
);
  // one-hot select of slot k where t == k + LANE
  always_comb begin
    a = '0;
    b = '0;
    for (int k = 0; k < K_DEPTH; k++) begin
      if (t == TW'(k + LANE)) begin
        a = col_a[k];
        b = col_b[k];
      end
    end
  end
endmodule

module systolic_skew_feeder #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int K_DEPTH    = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_a,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_b,
  output logic                             out_valid,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_a,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_b,
  output logic                             tile_done
);
  localparam int SL = K_DEPTH + ARRAY_SIZE - 1;   // beats per tile
  localparam int FW = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
  localparam int TW = (SL > 1) ? $clog2(SL) : 1;
  localparam logic [FW-1:0] FILL_LAST = FW'(K_DEPTH - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(SL - 1);

  typedef enum logic {FILL, STREAM} state_t;

  state_t        state;
  logic [FW-1:0] fill_cnt;
  logic [TW-1:0] t;
  logic          hs;

  logic [K_DEPTH-1:0][ARRAY_SIZE-1:0][DATA_WIDTH-1:0] mem_a, mem_b;
  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]              skew_a, skew_b;

  assign in_ready = (state == FILL);
  assign hs       = in_valid & in_ready;

  // tile sequencer: fill K_DEPTH slots, then count out SL stream beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      fill_cnt <= '0;
      t        <= '0;
    end else begin
      case (state)
        FILL: if (hs) begin
          if (fill_cnt == FILL_LAST) begin
            fill_cnt <= '0;
            t        <= '0;
            state    <= STREAM;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        STREAM: begin
          if (t == T_LAST) begin
            t     <= '0;
            state <= FILL;
          end else begin
            t <= t + 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // tile buffer: written only on handshakes, so it is frozen while streaming
  always_ff @(posedge clk) begin
    if (hs) begin
      for (int k = 0; k < K_DEPTH; k++) begin
        if (fill_cnt == FW'(k)) begin
          mem_a[k] <= in_a;
          mem_b[k] <= in_b;
        end
      end
    end
  end

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [K_DEPTH-1:0][DATA_WIDTH-1:0] col_a, col_b;

    // slice lane i out of every buffered k-vector
    always_comb begin
      for (int k = 0; k < K_DEPTH; k++) begin
        col_a[k] = mem_a[k][i];
        col_b[k] = mem_b[k][i];
      end
    end

    systolic_skew_lane #(
      .K_DEPTH(K_DEPTH), .DATA_WIDTH(DATA_WIDTH), .TW(TW), .LANE(i)
    ) u_lane (
      .t(t), .col_a(col_a), .col_b(col_b), .a(skew_a[i]), .b(skew_b[i])
    );
  end

  // output beat register; zeros (not held data) whenever not streaming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      tile_done <= 1'b0;
    end else if (state == STREAM) begin
      out_valid <= 1'b1;
      out_a     <= skew_a;
      out_b     <= skew_b;
      tile_done <= (t == T_LAST);
    end else begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      tile_done <= 1'b0;
    end
  end
endmodule
